// File: rtl/systolic_feed_if.sv
// ----------------------------------------------------------------------------
// systolic_feed_if : BRAM read port, array edge buses and status of the feeder
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface systolic_feed_if #(
  parameter int N  = 12,
  parameter int AW = 9
);
  logic            start;
  logic [AW-1:0]   bram_addr;
  logic [7:0]      bram_dout;
  logic [N*8-1:0]  a_edge;
  logic [N*8-1:0]  b_edge;
  logic            edge_valid;
  logic            pe_clear;
  logic            busy;
  logic            done;
  logic [15:0]     cycle_count;

  modport master (
    input  start, bram_dout,
    output bram_addr, a_edge, b_edge, edge_valid, pe_clear, busy, done, cycle_count
  );

  modport slave (
    output start, bram_dout,
    input  bram_addr, a_edge, b_edge, edge_valid, pe_clear, busy, done, cycle_count
  );
endinterface

`default_nettype wire

// File: rtl/systolic_feed_sched.sv
// ----------------------------------------------------------------------------
// systolic_feed_sched : loads A/B from BRAM, streams skewed edge beats, drains.
// Optional run-length counter: define SCHED_CYCLE_CNT_EN.   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module systolic_feed_sched #(
  parameter int N  = 12,
  parameter int AW = 9
) (
  input  logic             clk,
  input  logic             reset,
  systolic_feed_if.master  bus
);

  localparam int MEM_WORDS = 2 * N * N;
  localparam int CW        = $clog2(MEM_WORDS + 1);
  localparam int IW        = $clog2(MEM_WORDS);
  localparam logic [CW-1:0] LOAD_LAST  = CW'(MEM_WORDS);
  localparam logic [CW-1:0] FEED_LAST  = CW'(2 * N - 2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [7:0]      bank [MEM_WORDS];
  logic [N*8-1:0]  a_next, b_next;

  logic [AW-1:0]   bram_addr_q;
  logic [N*8-1:0]  a_edge_q, b_edge_q;
  logic            edge_valid_q, pe_clear_q, busy_q, done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_n = S_LOAD;
          cnt_n   = '0;
        end
      end
      S_LOAD: begin
        if (cnt == LOAD_LAST) begin
          state_n = S_FEED;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_FEED: begin
        if (cnt == FEED_LAST) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_n = S_DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Read data arrives one cycle after its address, so slot cnt-1 lands now.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && cnt != '0) begin
      bank[IW'(cnt - 1'b1)] <= bus.bram_dout;
    end
  end

  // Beat t = cnt_n: row/column i is offset by i beats (diagonal skew).
  always_comb begin
    int k;
    a_next = '0;
    b_next = '0;
    k      = 0;
    if (state_n == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        k = int'(cnt_n) - i;
        if (k >= 0 && k < N) begin
          a_next[i*8 +: 8] = bank[IW'(i * N + k)];
          b_next[i*8 +: 8] = bank[IW'(N * N + k * N + i)];
        end
      end
    end
  end

  // Outputs are registered from the next-state view so they align with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      bram_addr_q  <= '0;
      a_edge_q     <= '0;
      b_edge_q     <= '0;
      edge_valid_q <= 1'b0;
      pe_clear_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      busy_q       <= (state_n != S_IDLE);
      done_q       <= (state_n == S_DONE);
      edge_valid_q <= (state_n == S_FEED);
      pe_clear_q   <= (state_n == S_LOAD) && (cnt_n == LOAD_LAST);
      a_edge_q     <= a_next;
      b_edge_q     <= b_next;
      if (state_n == S_LOAD) begin
        if (cnt_n != LOAD_LAST) begin
          bram_addr_q <= AW'(cnt_n);
        end
      end else begin
        bram_addr_q <= '0;
      end
    end
  end

  assign bus.bram_addr  = bram_addr_q;
  assign bus.a_edge     = a_edge_q;
  assign bus.b_edge     = b_edge_q;
  assign bus.edge_valid = edge_valid_q;
  assign bus.pe_clear   = pe_clear_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

`ifdef SCHED_CYCLE_CNT_EN
  logic [15:0] run_cnt, run_cnt_inc, cycle_count_q;

  assign run_cnt_inc = (run_cnt == 16'hFFFF) ? run_cnt : run_cnt + 16'd1;

  // The DONE cycle itself is part of the run, hence the incremented value.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt       <= '0;
      cycle_count_q <= '0;
    end else begin
      if (state == S_IDLE) begin
        if (bus.start) begin
          run_cnt <= '0;
        end
      end else begin
        run_cnt <= run_cnt_inc;
      end
      if (state == S_DONE) begin
        cycle_count_q <= run_cnt_inc;
      end
    end
  end

  assign bus.cycle_count = cycle_count_q;
`else
  assign bus.cycle_count = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_feed_sched.sv
// ----------------------------------------------------------------------------
// tb_systolic_feed_sched : directed N=2 bench with hand-computed beat tables.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_systolic_feed_sched;

  localparam int N  = 2;
  localparam int AW = 9;
`ifdef SCHED_CYCLE_CNT_EN
  localparam logic [31:0] EXP_CC = 32'd15;
`else
  localparam logic [31:0] EXP_CC = 32'd0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [7:0]  bram [8];
  logic [15:0] exp_a [3];
  logic [15:0] exp_b [3];

  systolic_feed_if #(.N(N), .AW(AW)) bus ();

  systolic_feed_sched #(.N(N), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.bram_dout <= bram[bus.bram_addr[2:0]];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_value({tag, "_addr"},  32'(bus.bram_addr),   32'd0);
    check_value({tag, "_a"},     32'(bus.a_edge),      32'd0);
    check_value({tag, "_b"},     32'(bus.b_edge),      32'd0);
    check_value({tag, "_ev"},    32'(bus.edge_valid),  32'd0);
    check_value({tag, "_clr"},   32'(bus.pe_clear),    32'd0);
    check_value({tag, "_busy"},  32'(bus.busy),        32'd0);
    check_value({tag, "_done"},  32'(bus.done),        32'd0);
  endtask

  // Called at the negedge of run cycle 0; returns at the negedge of cycle 15.
  task automatic check_run(input bit repulse);
    logic [31:0] e_addr;
    bit          e_ev;
    for (int c = 0; c <= 14; c++) begin
      bus.start = repulse && (c == 3 || c == 10 || c == 14);
      e_addr = (c <= 7) ? 32'(c) : (c == 8) ? 32'd7 : 32'd0;
      e_ev   = (c >= 9 && c <= 11);
      check_value($sformatf("busy@%0d", c), 32'(bus.busy),       32'd1);
      check_value($sformatf("addr@%0d", c), 32'(bus.bram_addr),  e_addr);
      check_value($sformatf("clr@%0d", c),  32'(bus.pe_clear),   32'(c == 8));
      check_value($sformatf("ev@%0d", c),   32'(bus.edge_valid), 32'(e_ev));
      check_value($sformatf("a@%0d", c),    32'(bus.a_edge),     e_ev ? 32'(exp_a[c-9]) : 32'd0);
      check_value($sformatf("b@%0d", c),    32'(bus.b_edge),     e_ev ? 32'(exp_b[c-9]) : 32'd0);
      check_value($sformatf("done@%0d", c), 32'(bus.done),       32'(c == 14));
      @(negedge clk);
    end
    bus.start = 1'b0;
    check_value("busy_after", 32'(bus.busy), 32'd0);
    check_value("done_after", 32'(bus.done), 32'd0);
    check_value("cycle_count", 32'(bus.cycle_count), EXP_CC);
  endtask

  initial begin
    bit saw_done;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 8; i++) bram[i] = 8'(i + 1);
    // Byte 0 is the low byte: a_edge = {row1, row0}, b_edge = {col1, col0}.
    exp_a[0] = 16'h0001; exp_b[0] = 16'h0005;
    exp_a[1] = 16'h0302; exp_b[1] = 16'h0607;
    exp_a[2] = 16'h0400; exp_b[2] = 16'h0800;

    reset     = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check_value("reset_cc", 32'(bus.cycle_count), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic run, then a back-to-back run started the cycle after done.
    bus.start = 1'b1;
    @(negedge clk);
    check_run(1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    check_run(1'b0);

    // start re-pulsed during LOAD, FEED and DONE must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    check_run(1'b1);

    // Reset during FEED beat 1 aborts the run without a done.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    check_value("pre_abort_ev", 32'(bus.edge_valid), 32'd1);
    check_value("pre_abort_a",  32'(bus.a_edge),     32'h0302);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("abort");
    check_value("abort_cc", 32'(bus.cycle_count), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done || bus.busy) saw_done = 1'b1;
      @(negedge clk);
    end
    check_value("abort_quiet", 32'(saw_done), 32'd0);

    // Fresh run after the abort completes normally.
    bus.start = 1'b1;
    @(negedge clk);
    check_run(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
